// File: rtl/mat_ram_xfer.sv
// Block-transfer master moving one DIM x DIM matrix between a valid/ready stream and a 32x32 single-port RAM.
// Optional build macro MATRIX_TRANSPOSE_EN enables column-major element ordering.
module mat_ram_xfer #(
   parameter int DIM = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mode,
   input  logic [4:0]  base,
   input  logic        transpose,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic        done,
   output logic        ram_cen,
   output logic        ram_wen,
   output logic [4:0]  ram_addr,
   output logic [31:0] ram_din,
   input  logic [31:0] ram_dout
);

   localparam int         L    = DIM * DIM;
   localparam logic [5:0] LAST = 6'(L - 1);

   typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

   state_t      state, state_n;
   logic [5:0]  cnt, cnt_n;
   logic [4:0]  base_q, base_n, base_sel;
   logic [5:0]  offset;
   logic [4:0]  elem_addr;
   logic        cen_n, wen_n, done_n;
   logic [4:0]  addr_n;
   logic [31:0] din_n;
   logic        rd_issue, advance, clear;
   logic        rd_p1, last_p1;

`ifdef MATRIX_TRANSPOSE_EN
   logic [2:0]  row, col, row_n, col_n;
   logic        tr_q, tr_n, tr_sel;
`else
   logic        unused_transpose;
   assign unused_transpose = transpose;
`endif

   assign busy     = (state != IDLE);
   assign in_ready = (state == WR);

   // In IDLE the first element is issued straight from the start-cycle inputs.
   always_comb begin
      base_sel = (state == IDLE) ? base : base_q;
`ifdef MATRIX_TRANSPOSE_EN
      tr_sel   = (state == IDLE) ? transpose : tr_q;
      offset   = tr_sel ? (6'(col) * 6'(DIM) + 6'(row)) : cnt;
`else
      offset   = cnt;
`endif
      elem_addr = 5'({1'b0, base_sel} + offset);
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      base_n   = base_q;
      cen_n    = 1'b0;
      wen_n    = 1'b0;
      addr_n   = ram_addr;
      din_n    = ram_din;
      done_n   = 1'b0;
      rd_issue = 1'b0;
      advance  = 1'b0;
      clear    = 1'b0;
`ifdef MATRIX_TRANSPOSE_EN
      tr_n     = tr_q;
      row_n    = row;
      col_n    = col;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               base_n = base;
`ifdef MATRIX_TRANSPOSE_EN
               tr_n   = transpose;
`endif
               if (mode) begin
                  state_n = WR;
               end else begin
                  state_n  = RD;
                  rd_issue = 1'b1;
               end
            end
         end
         WR: begin
            if (in_valid) begin
               cen_n  = 1'b1;
               wen_n  = 1'b1;
               addr_n = elem_addr;
               din_n  = in_data;
               if (cnt == LAST) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                  clear   = 1'b1;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         RD: rd_issue = 1'b1;
         DRAIN: begin
            done_n = last_p1;
            if (done) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (rd_issue) begin
         cen_n  = 1'b1;
         addr_n = elem_addr;
         if (cnt == LAST) begin
            state_n = DRAIN;
            clear   = 1'b1;
         end else begin
            advance = 1'b1;
         end
      end

      if (clear)        cnt_n = '0;
      else if (advance) cnt_n = cnt + 6'd1;

`ifdef MATRIX_TRANSPOSE_EN
      if (clear) begin
         row_n = '0;
         col_n = '0;
      end else if (advance) begin
         if (col == 3'(DIM - 1)) begin
            col_n = '0;
            row_n = row + 3'd1;
         end else begin
            col_n = col + 3'd1;
         end
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         base_q   <= '0;
         ram_cen  <= 1'b0;
         ram_wen  <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         done     <= 1'b0;
         rd_p1    <= 1'b0;
         last_p1  <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
`ifdef MATRIX_TRANSPOSE_EN
         tr_q     <= 1'b0;
         row      <= '0;
         col      <= '0;
`endif
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         base_q   <= base_n;
         ram_cen  <= cen_n;
         ram_wen  <= wen_n;
         ram_addr <= addr_n;
         ram_din  <= din_n;
         done     <= done_n;
         // Read pipeline: issue on pins -> RAM dout valid -> captured onto rd_data.
         rd_p1    <= ram_cen & ~ram_wen;
         last_p1  <= ram_cen & ~ram_wen & (state == DRAIN);
         rd_valid <= rd_p1;
         if (rd_p1) rd_data <= ram_dout;
`ifdef MATRIX_TRANSPOSE_EN
         tr_q     <= tr_n;
         row      <= row_n;
         col      <= col_n;
`endif
      end
   end

endmodule

// File: doc/mat_ram_xfer.md
Name: mat_ram_xfer

Overview:
- Block-transfer master for the 32x32-bit single-port matrix RAM: drives its cen/wen/addr/din pins and consumes its registered dout.
- Moves one DIM x DIM matrix, DIM*DIM consecutive words starting at a base address, between a valid/ready write stream and the RAM, or from the RAM to a read-data stream.
- Sits between the matrix datapath and the RAM instance.

Parameters:
- DIM, 4, matrix dimension. Legal 1..5 so that DIM*DIM <= 32. Transfer length L = DIM*DIM.

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin transfer; sampled only in IDLE
- mode  in  1  1 = write (stream to RAM), 0 = read (RAM to stream); captured with start
- base  in  5  starting RAM word address; captured with start
- transpose  in  1  column-major order; captured with start; used only with MATRIX_TRANSPOSE_EN
- in_data  in  32  write-stream data
- in_valid  in  1  write-stream valid
- in_ready  out  1  write-stream ready
- rd_data  out  32  read-stream data
- rd_valid  out  1  read-stream valid, one-cycle pulse per word, no backpressure
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- ram_cen  out  1  RAM chip enable
- ram_wen  out  1  RAM write enable
- ram_addr  out  5  RAM address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data; valid the cycle after a read is issued

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. The reset has no effect on RAM contents.
- Reset mid-transfer:
  - Next cycle returns to IDLE with every output 0.
  - In-flight reads are discarded: no rd_valid and no done after the reset.
- Every RAM-side output is registered.
  - When ram_cen=0, ram_wen=0 also.
  - When ram_cen=0, ram_addr and ram_din hold their last values.
- States: IDLE, WR, RD, DRAIN.
  - IDLE: start=1 at edge of cycle s captures mode, base and transpose.
  - mode=1 goes to WR; mode=0 goes to RD and issues the first read in cycle s+1.
  - start is ignored whenever the block is not in IDLE.
- Element order and addressing:
  - Element k (0..L-1) has offset k. With transpose active, offset = (k mod DIM)*DIM + (k div DIM).
  - ram_addr = (base + offset) mod 32, so addresses wrap 31 -> 0.
- WR state:
  - in_ready=1 for every cycle of WR.
  - A handshake (in_valid & in_ready) at edge E registers ram_cen=1, ram_wen=1, ram_addr=element address and ram_din=in_data, visible the cycle after E.
  - A cycle without a handshake drives ram_cen=0.
  - The handshake for element L-1 sends the FSM to IDLE, drops in_ready, and pulses done in the same cycle the last write appears on the RAM pins.
- RD state:
  - Issues ram_cen=1, ram_wen=0 with consecutive element addresses for L cycles, s+1..s+L.
  - Each word is captured from ram_dout one cycle after its issue cycle; rd_data/rd_valid appear two cycles after the issue cycle.
  - After the last issue, the FSM enters DRAIN with ram_cen=0.
  - The first rd_valid is in cycle s+3; the last is in s+L+2, coincident with done. DRAIN then returns to IDLE.
- rd_valid is never asserted for write transfers. rd_data holds its last value when rd_valid=0.
- busy:
  - Read: 1 from cycle s+1 through the done cycle inclusive.
  - Write: 1 from cycle s+1 through the cycle of the last handshake edge. Then 0 in the done cycle, when state is IDLE.
- A start sampled in the done cycle of a write is accepted, because the state is already IDLE. A read issued that way observes the just-written data: the RAM writes at the end of the done cycle.
- in_valid outside WR is ignored.
- The element counter uses 6 bits, with terminal count L-1.

Optional Feature:
- Macro: MATRIX_TRANSPOSE_EN.
- Defined: the captured transpose bit selects column-major offsets for both read and write transfers. This requires row/column counters.
- Undefined: the transpose port is present but ignored; offsets are always row-major, and the row/column counters are not built.

Test Plan:
- DIM=4, base=0, write 0x100+k for k=0..15, in_valid low on every 3rd cycle -> mem[k]=0x100+k; exactly 16 cycles with ram_cen&ram_wen; one done pulse; in_ready=0 after the 16th handshake.
- After that write, read with base=0, start in cycle s -> rd_valid cycles s+3..s+18, rd_data=0x100..0x10F in order; done in cycle s+18; busy=0 in s+19.
- Wrap: write base=30, 16 words 0xA0+k -> ram_addr sequence 30,31,0,1,...,13; read-back from base 30 returns 0xA0..0xAF.
- With MATRIX_TRANSPOSE_EN, DIM=4: write row-major 0..15 at base 0, read with transpose=1 -> rd_data sequence 0,4,8,12,1,5,9,13,...,15.
- rst=1 for one cycle after the 5th read issue -> next cycle ram_cen=0, rd_valid=0, busy=0; no done pulse; a fresh start then completes normally.
- start pulsed with mode=1 during an active read -> ignored: read completes unchanged and no WR entry occurs.
